// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/BTB branch predictor.
package bp_pkg;

  typedef enum logic {
    BR_TYPE_BRANCH = 1'b0,
    BR_TYPE_JUMP   = 1'b1
  } br_type_e;

  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_MAX = 2'b11;
  localparam logic [1:0] CNT_MIN = 2'b00;

  // Two-bit saturating counter step; never wraps at either end.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
    end
    return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters, one combinational read port and
// one saturating-update write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_cnt,
  input  logic                 wr_en,
  input  logic [PHT_IDX_W-1:0] wr_idx,
  input  logic                 wr_taken
);

  localparam int unsigned Entries = 1 << PHT_IDX_W;

  logic [1:0] cnt_q [Entries];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= sat_update(cnt_q[wr_idx], wr_taken);
    end
  end

  // Read sees the pre-update value on a same-cycle read/write collision.
  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare (or bimodal) direction predictor with a direct-mapped BTB and a
// speculatively updated global history register repaired from EX.
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 6,
  parameter int unsigned BTB_IDX_W = 5,
  parameter int unsigned GHR_W     = 6,
  parameter int unsigned MODE      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          if_pc,
  input  logic                 if_fire,
  output logic                 pred_taken,
  output logic [31:0]          pred_next_pc,
  output logic [PHT_IDX_W-1:0] pred_pht_idx,
  output logic [GHR_W-1:0]     pred_ghr,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_is_branch,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic [PHT_IDX_W-1:0] upd_pht_idx,
  input  logic [GHR_W-1:0]     upd_ghr,
  input  logic                 upd_mispredict
);

  localparam int unsigned TagW = 30 - BTB_IDX_W;
  localparam int unsigned BtbN = 1 << BTB_IDX_W;

  logic [BtbN-1:0]  valid_q;
  logic [TagW-1:0]  tag_q [BtbN];
  logic [31:0]      tgt_q [BtbN];
  br_type_e         type_q [BtbN];
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic [BTB_IDX_W-1:0] rd_idx;
  logic [TagW-1:0]      rd_tag;
  logic                 hit;
  logic                 hit_jump;
  logic [1:0]           pht_cnt;
  logic [PHT_IDX_W-1:0] pc_bits;

  assign rd_idx   = if_pc[BTB_IDX_W+1:2];
  assign rd_tag   = if_pc[31:BTB_IDX_W+2];
  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign hit_jump = (type_q[rd_idx] == BR_TYPE_JUMP);
  assign pc_bits  = if_pc[PHT_IDX_W+1:2];

  always_comb begin
    pred_pht_idx = pc_bits;
    if (MODE != 0) begin
      pred_pht_idx = pc_bits ^ PHT_IDX_W'(ghr_q);
    end
  end

  assign pred_taken   = hit && (hit_jump || pht_cnt[1]);
  assign pred_next_pc = pred_taken ? tgt_q[rd_idx] : if_pc + 32'd4;
  assign pred_ghr     = ghr_q;

  // A set jump flag wins over the branch flag everywhere.
  logic upd_branch_only;
  logic pht_wr_en;
  logic btb_wr_en;
  logic [BTB_IDX_W-1:0] wr_idx;

  assign upd_branch_only = upd_is_branch && !upd_is_jump;
  assign pht_wr_en       = upd_valid && upd_branch_only;
  assign btb_wr_en       = upd_valid && upd_taken && (upd_is_branch || upd_is_jump);
  assign wr_idx          = upd_pc[BTB_IDX_W+1:2];

  bp_pht #(
    .PHT_IDX_W (PHT_IDX_W)
  ) u_pht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (pred_pht_idx),
    .rd_cnt   (pht_cnt),
    .wr_en    (pht_wr_en),
    .wr_idx   (upd_pht_idx),
    .wr_taken (upd_taken)
  );

  // Repair beats the speculative shift issued in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) begin
      if (upd_branch_only) begin
        ghr_d = {upd_ghr[GHR_W-2:0], upd_taken};
      end else begin
        ghr_d = upd_ghr;
      end
    end else if (if_fire && hit && !hit_jump) begin
      ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q   <= '0;
      valid_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (btb_wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag, target and type are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (btb_wr_en) begin
      tag_q[wr_idx]  <= upd_pc[31:BTB_IDX_W+2];
      tgt_q[wr_idx]  <= upd_target;
      type_q[wr_idx] <= upd_is_jump ? BR_TYPE_JUMP : BR_TYPE_BRANCH;
    end
  end

  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc[1:0];

endmodule
